// File: rtl/ofm_post_proc.sv
//==============================================================================
// ofm_post_proc: bias add, optional ReLU, rounded requantise/saturate, then a
// show-ahead output FIFO with tile framing and a sticky drop flag.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ofm_post_proc #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int TILE_WORDS    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] in_data,
    input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] bias,
    input  logic [3:0]                            shift,
    input  logic                                  relu_en,
    input  logic                                  ovf_clr,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   out_data,
    output logic                                  out_last,
    output logic                                  overflow,
    output logic                                  busy
);

    localparam int IW = 2 * DATA_WIDTH;
    localparam int SW = IW + 1;
    // Headroom for the largest rounding constant (2^14) on top of the 17-bit sum
    localparam int RW = (IW + 2 > 17) ? IW + 2 : 17;
    localparam int OW = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    logic          v1_q;
    logic          v2_q;
    logic [OW-1:0] s2_d;
    logic [OW-1:0] s2_q;

    for (genvar g = 0; g < SYSTOLIC_SIZE; g++) begin : g_lane
        logic signed [IW-1:0]         acc;
        logic signed [IW-1:0]         bia;
        logic signed [SW-1:0]         sum_d;
        logic signed [SW-1:0]         sum_q;
        logic signed [RW-1:0]         rnd;
        logic signed [RW-1:0]         shr;
        logic        [DATA_WIDTH-1:0] sat;

        assign acc = in_data[g*IW +: IW];
        assign bia = bias[g*IW +: IW];

        always_comb begin
            sum_d = $signed({acc[IW-1], acc}) + $signed({bia[IW-1], bia});
            if (relu_en && sum_d[SW-1]) begin
                sum_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (in_valid) begin
                sum_q <= sum_d;
            end
        end

        always_comb begin
            rnd = {{(RW-SW){sum_q[SW-1]}}, sum_q};
            if (shift != 4'd0) begin
                rnd = rnd + (RW'(1) << (shift - 4'd1));
            end
            shr = rnd >>> shift;
            if (shr > SAT_MAX) begin
                sat = SAT_MAX[DATA_WIDTH-1:0];
            end else if (shr < SAT_MIN) begin
                sat = SAT_MIN[DATA_WIDTH-1:0];
            end else begin
                sat = shr[DATA_WIDTH-1:0];
            end
        end

        assign s2_d[g*DATA_WIDTH +: DATA_WIDTH] = sat;
    end

    always_ff @(posedge clk) begin
        if (v1_q) begin
            s2_q <= s2_d;
        end
    end

    logic [OW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic [TW-1:0] tile_q;
    logic [TW-1:0] tile_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          empty;
    logic          full;
    logic          do_rd;
    logic          do_wr;
    logic          drop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = !empty && out_ready;
        // A read on the same edge frees the slot, so a full FIFO still accepts
        do_wr    = v2_q && (!full || do_rd);
        drop     = v2_q && full && !do_rd;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        tile_d = tile_q;
        if (do_rd) begin
            tile_d = (tile_q == TW'(TILE_WORDS - 1)) ? '0 : tile_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tile_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            v1_q     <= in_valid;
            v2_q     <= v1_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tile_q   <= tile_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s2_q;
        end
    end

    always_comb begin
        out_valid = !empty;
        out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        out_last  = !empty && (tile_q == TW'(TILE_WORDS - 1));
        overflow  = ovf_q;
        busy      = v1_q || v2_q || !empty;
    end

endmodule

`default_nettype wire

// File: tb/tb_ofm_post_proc.sv
//==============================================================================
// tb_ofm_post_proc: directed vector table plus hand-written FIFO, tile framing
// and reset sequences for ofm_post_proc.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ofm_post_proc;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int IW = 16;
    localparam int OW = N * DW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic [N*IW-1:0] in_data = '0;
    logic [N*IW-1:0] bias    = '0;
    logic [3:0]    shift     = 4'd0;
    logic          relu_en   = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          overflow;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ofm_post_proc #(
        .SYSTOLIC_SIZE(N),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (4),
        .TILE_WORDS   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .bias     (bias),
        .shift    (shift),
        .relu_en  (relu_en),
        .ovf_clr  (ovf_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .overflow (overflow),
        .busy     (busy)
    );

    typedef struct packed {
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic [3:0]  sh;
        logic        relu;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t vt [14];

    logic [OW-1:0] got_d [$];
    logic          got_l [$];
    bit            mon_en     = 1'b0;
    bit            stall_en   = 1'b0;
    bit            stall_prev = 1'b0;
    logic [OW-1:0] prev_data  = '0;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Lane 0 gets (a0,b0); lanes 1..N-1 get (a1,b1)
    task automatic fill(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] b0, input logic [15:0] b1);
        for (int i = 0; i < N; i++) begin
            in_data[i*IW +: IW] = (i == 0) ? a0 : a1;
            bias[i*IW +: IW]    = (i == 0) ? b0 : b1;
        end
    endtask

    function automatic logic [OW-1:0] rep(input logic [7:0] e0, input logic [7:0] e1);
        logic [OW-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*DW +: DW] = (i == 0) ? e0 : e1;
        end
        return r;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_overflow",  overflow,  1'b0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_out_data",  out_data,  '0);
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        if (stall_en) begin
            if (stall_prev) begin
                chk("stall_hold", out_data, prev_data);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_list [4];
        int         sent;
        int         seen;
        bit         prev_rdy;

        //             a0        b0        a1        b1        sh     relu  e0     e1
        vt[0]  = '{16'h0100, 16'h0010, 16'h0040, 16'h0003, 4'd4,  1'b0, 8'h11, 8'h04};
        vt[1]  = '{16'hFF00, 16'h0000, 16'hFFC0, 16'h0003, 4'd0,  1'b1, 8'h00, 8'h00};
        vt[2]  = '{16'hFF00, 16'h0000, 16'hFFC0, 16'h0003, 4'd0,  1'b0, 8'h80, 8'hC3};
        vt[3]  = '{16'h0018, 16'h0000, 16'h0040, 16'h0003, 4'd4,  1'b0, 8'h02, 8'h04};
        vt[4]  = '{16'h7FFF, 16'h7FFF, 16'h0040, 16'h0003, 4'd0,  1'b0, 8'h7F, 8'h43};
        vt[5]  = '{16'h8000, 16'h8000, 16'h0040, 16'h0003, 4'd15, 1'b0, 8'hFE, 8'h00};
        vt[6]  = '{16'h7FFF, 16'h7FFF, 16'hFFC0, 16'h0003, 4'd15, 1'b0, 8'h02, 8'h00};
        vt[7]  = '{16'hFFE8, 16'h0000, 16'hFFC0, 16'h0003, 4'd4,  1'b0, 8'hFF, 8'hFC};
        vt[8]  = '{16'hFFE7, 16'h0000, 16'h0040, 16'h0003, 4'd4,  1'b0, 8'hFE, 8'h04};
        vt[9]  = '{16'h0064, 16'hFFFD, 16'hFFC0, 16'h0003, 4'd1,  1'b0, 8'h31, 8'hE2};
        vt[10] = '{16'h0005, 16'h0000, 16'hFFC0, 16'h0003, 4'd1,  1'b1, 8'h03, 8'h00};
        vt[11] = '{16'h0001, 16'h0000, 16'h0040, 16'h0003, 4'd1,  1'b0, 8'h01, 8'h22};
        vt[12] = '{16'h03FF, 16'h0000, 16'h0040, 16'h0003, 4'd2,  1'b0, 8'h7F, 8'h11};
        vt[13] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 4'd0,  1'b1, 8'h00, 8'h00};

        #1;
        do_reset();

        // Arithmetic table with exact T+3 latency
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            fill(vt[i].a0, vt[i].a1, vt[i].b0, vt[i].b1);
            shift    = vt[i].sh;
            relu_en  = vt[i].relu;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("vec%0d_t2_valid", i), out_valid, 1'b0);
            tick();
            chk($sformatf("vec%0d_t3_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_data", i), out_data, rep(vt[i].e0, vt[i].e1));
            tick();
        end
        shift   = 4'd0;
        relu_en = 1'b0;

        // Overflow: seven words into a stalled 4-deep FIFO
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            fill(16'(k + 1), 16'(k + 1), 16'h0, 16'h0);
            in_valid = 1'b1;
            tick();
            if (k == 5) chk("ovf_after_4th", overflow, 1'b0);
            if (k == 6) chk("ovf_after_5th", overflow, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("full_valid", out_valid, 1'b1);
        chk("full_head",  out_data,  rep(8'd1, 8'd1));
        chk("full_busy",  busy,      1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Clear coinciding with a drop keeps the flag set
        fill(16'd9, 16'd9, 16'h0, 16'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_drop", overflow, 1'b1);
        chk("drop_head_kept",  out_data, rep(8'd1, 8'd1));

        // Full FIFO: read and write on the same edge
        fill(16'd10, 16'd10, 16'h0, 16'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        chk("rdwr_head", out_data, rep(8'd1, 8'd1));
        tick();
        exp_list[0] = 8'd2;
        exp_list[1] = 8'd3;
        exp_list[2] = 8'd4;
        exp_list[3] = 8'd10;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d_valid", j), out_valid, 1'b1);
            chk($sformatf("drain%0d_data", j),  out_data,  rep(exp_list[j], exp_list[j]));
            tick();
        end
        chk("drained_valid", out_valid, 1'b0);
        chk("drained_busy",  busy,      1'b0);
        chk("ovf_sticky",    overflow,  1'b1);

        // Tile framing on a back-to-back stream of 32 words
        do_reset();
        out_ready = 1'b1;
        got_d.delete();
        got_l.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            fill(16'(k), 16'(k), 16'h0, 16'h0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40 && got_d.size() < 32; c++) tick();
        mon_en = 1'b0;
        chk("stream_count", 32'(got_d.size()), 32'd32);
        for (int k = 0; k < 32 && k < got_d.size(); k++) begin
            chk($sformatf("stream%0d_data", k), got_d[k], rep(8'(k), 8'(k)));
            chk($sformatf("stream%0d_last", k), got_l[k], (k == 15 || k == 31));
        end

        // Same ordering under random consumer stalls
        do_reset();
        got_d.delete();
        got_l.delete();
        mon_en   = 1'b1;
        stall_en = 1'b1;
        sent     = 0;
        prev_rdy = 1'b1;
        for (int c = 0; c < 400 && got_d.size() < 32; c++) begin
            if ((c % 2 == 0) && (sent < 32)) begin
                fill(16'(64 + sent), 16'(64 + sent), 16'h0, 16'h0);
                in_valid = 1'b1;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = prev_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_rdy  = out_ready;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b0;
        stall_en  = 1'b0;
        chk("rand_count",    32'(got_d.size()), 32'd32);
        chk("rand_overflow", overflow, 1'b0);
        for (int k = 0; k < 32 && k < got_d.size(); k++) begin
            chk($sformatf("rand%0d_data", k), got_d[k], rep(8'(64 + k), 8'(64 + k)));
            chk($sformatf("rand%0d_last", k), got_l[k], (k == 15 || k == 31));
        end

        // Reset with three words buffered and one in flight
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fill(16'(k + 1), 16'(k + 1), 16'h0, 16'h0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_busy",  busy,      1'b1);
        do_reset();
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("no_stale_words", 32'(seen), 32'd0);
        fill(16'd7, 16'd7, 16'h0, 16'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_t2_valid", out_valid, 1'b0);
        tick();
        chk("post_rst_t3_valid", out_valid, 1'b1);
        chk("post_rst_data",     out_data,  rep(8'd7, 8'd7));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
